adder_sum_accumulator: RTL and testbench



---
 rtl/adder_sum_accumulator.sv | 104 ++++++++++
 tb/tb_adder_sum_accumulator.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_accumulator.sv
// Accumulates BATCH {cout,sum} samples from the 4-bit adder into a wide
// running total, handed off through a valid/ready result handshake.
module adder_sum_accumulator #(
    parameter int ACC_W = 8,
    parameter int BATCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             cout,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic [3:0]       count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [3:0] BATCH_N = 4'(BATCH);
    localparam bit         SINGLE  = (BATCH == 1);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [3:0]       cnt;
    logic             ovf;

    logic [ACC_W-1:0] samp;
    logic [ACC_W:0]   acc_nx;
    logic [3:0]       cnt_nx;

    // Zero-extended sample, widened add exposing the carry, next count
    always_comb begin
        samp   = {{(ACC_W-5){1'b0}}, cout, sum};
        acc_nx = {1'b0, acc} + {1'b0, samp};
        cnt_nx = cnt + 4'd1;
    end

    // Handshake flags decode straight from state
    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    assign acc_out  = acc;
    assign overflow = ovf;
    assign count    = cnt;

    // Batch FSM; clear outranks any accept or deliver in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= samp;
                        cnt   <= 4'd1;
                        ovf   <= 1'b0;
                        state <= SINGLE ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_nx[ACC_W-1:0];
                        ovf <= ovf | acc_nx[ACC_W];
                        cnt <= cnt_nx;
                        if (cnt_nx == BATCH_N) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: table-driven batches with a result
// scoreboard, plus reset, backpressure, clear and overflow sequences.
module tb_adder_sum_accumulator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic       cout;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc_out;
    logic       overflow;
    logic [3:0] count;

    logic       b_in_valid;
    logic       b_in_ready;
    logic [3:0] b_sum;
    logic       b_cout;
    logic       b_clear;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [7:0] b_acc_out;
    logic       b_overflow;
    logic [3:0] b_count;

    adder_sum_accumulator #(.ACC_W(8), .BATCH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .cout(cout), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .overflow(overflow), .count(count)
    );

    adder_sum_accumulator #(.ACC_W(8), .BATCH(15)) dut15 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sum(b_sum), .cout(b_cout), .clear(b_clear),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_out(b_acc_out), .overflow(b_overflow), .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic [7:0]      vm;
        logic [7:0][4:0] val;
        int              eacc;
    } vec_t;

    typedef struct {
        int acc;
        int ovf;
        int cnt;
    } exp_t;

    vec_t tbl[4];
    exp_t q[$];
    int   total;
    int   bad;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic run_batch(input int idx, input bit dlv);
        vec_t r;
        exp_t e;
        int   mc;
        r  = tbl[idx];
        mc = 0;
        for (int c = 0; c < r.n; c++) begin
            in_valid    = r.vm[c];
            {cout, sum} = r.val[c];
            if (r.vm[c]) begin
                mc++;
                if (mc == 4) begin
                    q.push_back('{acc: r.eacc, ovf: 0, cnt: 4});
                end
            end
            @(negedge clk);
            chk("count", count, mc);
            chk("out_valid", out_valid, (mc == 4) ? 1 : 0);
        end
        in_valid = 1'b0;
        chk("result_ready", (out_valid && q.size() > 0) ? 1 : 0, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("acc_out", acc_out, e.acc);
            chk("overflow", overflow, e.ovf);
            chk("hold_count", count, e.cnt);
        end
        if (dlv) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk("dlv_out_valid", out_valid, 0);
            chk("dlv_in_ready", in_ready, 1);
            chk("dlv_acc", acc_out, 0);
            chk("dlv_count", count, 0);
        end
    endtask

    initial begin
        int tot;
        total = 0;
        bad   = 0;

        tbl[0] = '{n: 4, vm: 8'h0f,
                   val: {5'd0, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd31, 5'd5},
                   eacc: 45};
        tbl[1] = '{n: 7, vm: 8'h69,
                   val: {5'd0, 5'd20, 5'd10, 5'd0, 5'd4, 5'd0, 5'd0, 5'd3},
                   eacc: 37};
        tbl[2] = '{n: 4, vm: 8'h0f,
                   val: {5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd31, 5'd31},
                   eacc: 124};
        tbl[3] = '{n: 5, vm: 8'h1d,
                   val: {5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'd2, 5'd17, 5'd1},
                   eacc: 10};

        rst         = 1'b1;
        in_valid    = 1'b0;
        sum         = 4'd0;
        cout        = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_sum       = 4'd0;
        b_cout      = 1'b0;
        b_clear     = 1'b0;
        b_out_ready = 1'b0;

        #2;
        chk("rst_acc", acc_out, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        in_valid    = 1'b1;
        {cout, sum} = 5'd10;
        @(negedge clk);
        {cout, sum} = 5'd6;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_count", count, 2);
        chk("pre_rst_acc", acc_out, 16);
        rst = 1'b1;
        #1;
        chk("async_rst_acc", acc_out, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        #2;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_batch(i, 1'b1);
        end

        run_batch(0, 1'b0);
        in_valid    = 1'b1;
        {cout, sum} = 5'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_acc", acc_out, 45);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_count", count, 4);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_dlv_out_valid", out_valid, 0);
        chk("bp_dlv_in_ready", in_ready, 1);
        chk("bp_dlv_count", count, 0);
        @(negedge clk);
        chk("bp_take_count", count, 1);
        chk("bp_take_acc", acc_out, 7);

        {cout, sum} = 5'd8;
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_pre_count", count, 2);
        chk("clr_pre_acc", acc_out, 15);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_acc", acc_out, 0);
        chk("clr_in_ready", in_ready, 1);
        chk("clr_out_valid", out_valid, 0);
        in_valid    = 1'b1;
        {cout, sum} = 5'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("clr_restart_count", count, 1);
        chk("clr_restart_acc", acc_out, 3);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        run_batch(2, 1'b0);
        clear     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("clrdlv_out_valid", out_valid, 0);
        chk("clrdlv_acc", acc_out, 0);
        chk("clrdlv_count", count, 0);
        chk("clrdlv_in_ready", in_ready, 1);

        tot        = 0;
        b_in_valid = 1'b1;
        b_cout     = 1'b1;
        b_sum      = 4'd15;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            tot += 31;
            chk("ovf_acc", b_acc_out, tot % 256);
            chk("ovf_flag", b_overflow, (tot > 255) ? 1 : 0);
            chk("ovf_out_valid", b_out_valid, (k == 15) ? 1 : 0);
            chk("ovf_count", b_count, k);
        end
        b_in_valid = 1'b0;
        chk("ovf_final_acc", b_acc_out, 209);
        chk("ovf_final_flag", b_overflow, 1);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk("ovf_after_dlv", b_overflow, 0);
        chk("ovf_after_out_valid", b_out_valid, 0);
        chk("ovf_after_in_ready", b_in_ready, 1);

        chk("sb_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
